intra4x4_mode_decide: RTL and testbench

Sequential mode-decision stage for luma 4x4 intra prediction. It sits directly downstream of the residual stage and consumes its eight per-mode 16-sample residual blocks. For each mode it accumulates a sum of absolute differences (SAD) and selects the mode with the minimum SAD. It then reports the H.264 mode number and SAD of the winner to the transform/mode-signalling logic.

---
 rtl/intra4x4_mode_decide.sv | 168 ++++++++++++++++
 tb/tb_intra4x4_mode_decide.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/intra4x4_mode_decide.sv
// Luma 4x4 intra mode decision: latches the per-mode residuals, accumulates SADs row by row and picks the minimum.
// Build option INTRA4X4_DC_MODE_EN adds the dcres input and mode 2 (DC) as a candidate.
module intra4x4_mode_decide (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0][7:0] vres,
  input  logic [15:0][7:0] hres,
  input  logic [15:0][7:0] ddlres,
  input  logic [15:0][7:0] ddrres,
  input  logic [15:0][7:0] vrres,
  input  logic [15:0][7:0] hdres,
  input  logic [15:0][7:0] vlres,
  input  logic [15:0][7:0] hures,
`ifdef INTRA4X4_DC_MODE_EN
  input  logic [15:0][7:0] dcres,
`endif
  output logic             busy,
  output logic             done,
  output logic [3:0]       best_mode,
  output logic [11:0]      best_sad
);

  localparam int NM = 9;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_COMPARE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       row_q, row_d;
  logic [3:0]       cand_q, cand_d;
  logic [15:0][7:0] res_in [NM];
  logic [15:0][7:0] res_q  [NM];
  logic [11:0]      sad_q  [NM];
  logic [11:0]      row_sum [NM];
  logic [3:0]       run_mode_q;
  logic [11:0]      run_sad_q;
  logic [3:0]       best_mode_q;
  logic [11:0]      best_sad_q;
  logic             done_q;

  // |x| of a signed byte; 8'h80 yields 8'd128, which still fits unsigned.
  function automatic logic [7:0] abs8(input logic [7:0] s);
    return s[7] ? (~s + 8'd1) : s;
  endfunction

  // Slots are indexed by H.264 mode number; slot 2 stays zero without DC.
  always_comb begin
    res_in[0] = vres;
    res_in[1] = hres;
`ifdef INTRA4X4_DC_MODE_EN
    res_in[2] = dcres;
`else
    res_in[2] = '0;
`endif
    res_in[3] = ddlres;
    res_in[4] = ddrres;
    res_in[5] = vrres;
    res_in[6] = hdres;
    res_in[7] = vlres;
    res_in[8] = hures;
  end

  always_comb begin
    for (int m = 0; m < NM; m++) begin
      row_sum[m] = '0;
      for (int k = 0; k < 4; k++) begin
        row_sum[m] = row_sum[m] + 12'(abs8(res_q[m][{row_q, 2'(k)}]));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      cand_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      cand_q  <= cand_d;
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    cand_d  = cand_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          row_d   = '0;
        end
      end
      S_ACCUM: begin
        row_d = row_q + 2'd1;
        if (row_q == 2'd3) begin
          state_d = S_COMPARE;
          cand_d  = '0;
        end
      end
      S_COMPARE: begin
        if (cand_q == 4'd8) begin
          state_d = S_DONE;
        end else begin
`ifdef INTRA4X4_DC_MODE_EN
          cand_d = cand_q + 4'd1;
`else
          cand_d = (cand_q == 4'd1) ? 4'd3 : cand_q + 4'd1;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < NM; m++) begin
        res_q[m] <= '0;
        sad_q[m] <= '0;
      end
    end else if (state_q == S_IDLE && start) begin
      for (int m = 0; m < NM; m++) begin
        res_q[m] <= res_in[m];
        sad_q[m] <= '0;
      end
    end else if (state_q == S_ACCUM) begin
      for (int m = 0; m < NM; m++) begin
        sad_q[m] <= sad_q[m] + row_sum[m];
      end
    end
  end

  // Strict less-than keeps the lower mode number on ties.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_mode_q <= '0;
      run_sad_q  <= '0;
    end else if (state_q == S_COMPARE) begin
      if (cand_q == 4'd0 || sad_q[cand_q] < run_sad_q) begin
        run_mode_q <= cand_q;
        run_sad_q  <= sad_q[cand_q];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_mode_q <= '0;
      best_sad_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        best_mode_q <= run_mode_q;
        best_sad_q  <= run_sad_q;
      end
    end
  end

  // The done cycle still counts as busy, so busy drops together with done.
  assign busy      = (state_q != S_IDLE) | done_q;
  assign done      = done_q;
  assign best_mode = best_mode_q;
  assign best_sad  = best_sad_q;

endmodule

// File: tb/tb_intra4x4_mode_decide.sv
// Bench for intra4x4_mode_decide: random and directed blocks against a SAD/min reference model.
// Follows the INTRA4X4_DC_MODE_EN build option of the design.
module tb_intra4x4_mode_decide;

`ifdef INTRA4X4_DC_MODE_EN
  localparam bit HAS_DC = 1'b1;
  localparam int LAT    = 14;
`else
  localparam bit HAS_DC = 1'b0;
  localparam int LAT    = 13;
`endif
  localparam int W = 48;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [15:0][7:0] res [0:8];
  logic        busy;
  logic        done;
  logic [3:0]  best_mode;
  logic [11:0] best_sad;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [3:0]  hold_mode;
  logic [11:0] hold_sad;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  intra4x4_mode_decide dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .vres      (res[0]),
    .hres      (res[1]),
    .ddlres    (res[3]),
    .ddrres    (res[4]),
    .vrres     (res[5]),
    .hdres     (res[6]),
    .vlres     (res[7]),
    .hures     (res[8]),
`ifdef INTRA4X4_DC_MODE_EN
    .dcres     (res[2]),
`endif
    .busy      (busy),
    .done      (done),
    .best_mode (best_mode),
    .best_sad  (best_sad)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: SAD per candidate mode, minimum with ties to the lower mode number.
  function automatic logic [15:0] model();
    int bm, bs, s, v;
    bm = -1;
    bs = 0;
    for (int m = 0; m < 9; m++) begin
      if (m == 2 && !HAS_DC) continue;
      s = 0;
      for (int i = 0; i < 16; i++) begin
        v = int'($signed(res[m][i]));
        s += (v < 0) ? -v : v;
      end
      if (bm < 0 || s < bs) begin
        bm = m;
        bs = s;
      end
    end
    return {4'(bm), 12'(bs)};
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: cycle %0d mode %0d sad %0d with nothing expected", cyc, best_mode, best_sad);
      end else begin
        mon_e = exp_q.pop_front();
        chk("done_cycle", cyc, int'(mon_e[47:16]));
        chk("best_mode", int'(best_mode), int'(mon_e[15:12]));
        chk("best_sad", int'(best_sad), int'(mon_e[11:0]));
      end
    end
  end

  // driver tasks
  task automatic fill(input int m, input logic [7:0] v);
    for (int i = 0; i < 16; i++) res[m][i] = v;
  endtask

  task automatic fill_all(input logic [7:0] v);
    for (int m = 0; m < 9; m++) fill(m, v);
  endtask

  task automatic rand_data();
    int p;
    for (int m = 0; m < 9; m++) begin
      p = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) begin
        case (p)
          0:       res[m][i] = 8'($urandom);
          1:       res[m][i] = 8'($urandom_range(0, 4)) - 8'd2;
          2:       res[m][i] = 8'h80;
          default: res[m][i] = 8'($urandom_range(0, 1));
        endcase
      end
    end
  endtask

  task automatic push_exp();
    logic [15:0] r;
    r = model();
    exp_q.push_back({32'(cyc + 1 + LAT), r});
    hold_mode = r[15:12];
    hold_sad  = r[11:0];
  endtask

  // Called just after a rising edge; the next edge samples start.
  task automatic issue();
    push_exp();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    rand_data();
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 60) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: busy %0d pending %0d after %0d cycles", busy, exp_q.size(), n);
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
    chk("hold_mode", int'(best_mode), int'(hold_mode));
    chk("hold_sad", int'(best_sad), int'(hold_sad));
    chk("idle_busy", int'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    start = 1'b0;
    fill_all(8'h00);
    hold_mode = '0;
    hold_sad  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_best_mode", int'(best_mode), 0);
    chk("rst_best_sad", int'(best_sad), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // all zero
    fill_all(8'h00);
    issue();
    wait_done();

    // H wins with |-1| per sample
    fill_all(8'h02);
    fill(1, 8'hFF);
    issue();
    wait_done();

    // full-scale -128 everywhere
    fill_all(8'h80);
    issue();
    wait_done();

    // HU wins, then DDL ties with it and takes precedence
    fill_all(8'h10);
    fill(0, 8'h03);
    fill(1, 8'h03);
    fill(8, 8'h01);
    issue();
    wait_done();
    fill_all(8'h10);
    fill(0, 8'h03);
    fill(1, 8'h03);
    fill(8, 8'h01);
    fill(3, 8'h01);
    issue();
    wait_done();

    // start held high, data churning while busy
    for (int n = 0; n < 4; n++) begin
      rand_data();
      push_exp();
      start = 1'b1;
      @(posedge clk); #1;
      if (n == 3) begin
        start = 1'b0;
      end else begin
        repeat (LAT) begin
          rand_data();
          @(posedge clk); #1;
        end
      end
    end
    start = 1'b0;
    wait_done();

    // reset in the middle of ACCUM
    fill_all(8'h05);
    fill(4, 8'h00);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_best_mode", int'(best_mode), 0);
    chk("abort_best_sad", int'(best_sad), 0);
    hold_mode = '0;
    hold_sad  = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue();
    wait_done();

    // random blocks with occasional gaps
    for (int t = 0; t < 40; t++) begin
      rand_data();
      issue();
      wait_done();
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
